// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared types and constants for the transmit-side bit unpacker
package viterbi_pkg;
  typedef enum logic [1:0] {UNP_IDLE, UNP_SHIFT, UNP_TAIL} unp_state_t;
  localparam int BYTE_W = 8;
  localparam int K = 7;
  localparam int TAIL_BITS_DEF = K - 1;
endpackage

// File: rtl/byte_unpacker_8x.sv
// byte_unpacker_8x: serializes bytes LSB first at 1 bit/cycle with frame marking.
// Define BYTE_UNPACKER_TAIL_ZEROS_EN to append TAIL_BITS zero tail bits per frame.
module byte_unpacker_8x
  import viterbi_pkg::*;
#(
  parameter int TAIL_BITS = TAIL_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              in_last,
  output logic              out_bit_valid,
  input  logic              out_bit_ready,
  output logic              out_bit,
  output logic              out_last,
  output logic              out_tail
);
  unp_state_t state, state_nxt;
  logic [BYTE_W-1:0] shift_reg;
  logic [2:0] bit_idx;
  logic last_q, in_fire, out_fire, byte_done, tail_go;
  if (TAIL_BITS < 1 || TAIL_BITS > 15) begin : g_bad_tail
    $error("TAIL_BITS must be in 1..15");
  end
`ifdef BYTE_UNPACKER_TAIL_ZEROS_EN
  localparam logic [3:0] TAIL_LAST = 4'(TAIL_BITS - 1);
  logic [3:0] tail_cnt;
  assign tail_go = last_q;
`else
  assign tail_go = 1'b0;
`endif
  assign byte_done = (state == UNP_SHIFT) && (bit_idx == 3'd7);
  assign out_fire  = out_bit_valid && out_bit_ready;
  assign in_fire   = in_valid && in_ready;
  // the reload slot opens only while the final data bit is leaving
  assign in_ready  = rst_n && ((state == UNP_IDLE) || (byte_done && out_bit_ready && !tail_go));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= UNP_IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    if (state == UNP_IDLE && in_fire) state_nxt = UNP_SHIFT;
    if (byte_done && out_fire) state_nxt = tail_go ? UNP_TAIL : in_fire ? UNP_SHIFT : UNP_IDLE;
`ifdef BYTE_UNPACKER_TAIL_ZEROS_EN
    if (state == UNP_TAIL && out_fire && tail_cnt == TAIL_LAST) state_nxt = UNP_IDLE;
`endif
  end
  // shifting in zeros leaves shift_reg empty after bit 7, so tail bits come out as 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_idx   <= '0;
      last_q    <= 1'b0;
    end else if (in_fire) begin
      shift_reg <= in_byte;
      bit_idx   <= '0;
      last_q    <= in_last;
    end else if (out_fire && state == UNP_SHIFT) begin
      shift_reg <= shift_reg >> 1;
      bit_idx   <= byte_done ? bit_idx : bit_idx + 3'd1;
    end
  end
`ifdef BYTE_UNPACKER_TAIL_ZEROS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tail_cnt <= '0;
    else if (byte_done && out_fire) tail_cnt <= '0;
    else if (state == UNP_TAIL && out_fire) tail_cnt <= tail_cnt + 4'd1;
  end
`endif
  always_comb begin
    out_bit_valid = state != UNP_IDLE;
    out_bit       = shift_reg[0];
`ifdef BYTE_UNPACKER_TAIL_ZEROS_EN
    out_tail      = state == UNP_TAIL;
    out_last      = (state == UNP_TAIL) && (tail_cnt == TAIL_LAST);
`else
    out_tail      = 1'b0;
    out_last      = byte_done && last_q;
`endif
  end
endmodule

// File: doc/byte_unpacker_8x.md
Name: byte_unpacker_8x

Overview:
- Serializes a byte stream into a bit stream, LSB first, with valid/ready handshakes on both sides.
- Sits on the transmit side ahead of the convolutional encoder. It is the inverse of the decoder-side bit packer.
- Marks frame boundaries and can append encoder-termination tail bits.
- Sustains 1 bit/cycle with no bubble between consecutive bytes.

Parameters:
- TAIL_BITS, 6, number of zero tail bits appended per frame (K-1 for K=7). Legal range 1..15. Used only with TAIL_ZEROS_EN.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_byte/in_last valid
- in_ready  output  1  unpacker can accept a byte this cycle
- in_byte  input  8  byte to serialize; bit 0 is sent first
- in_last  input  1  this byte ends the frame
- out_bit_valid  output  1  out_bit valid
- out_bit_ready  input  1  downstream consumer accepts the bit
- out_bit  output  1  serialized bit
- out_last  output  1  final bit of the frame (qualified by out_bit_valid)
- out_tail  output  1  current bit is a tail bit (tie-low semantics when TAIL_ZEROS_EN is undefined)

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE, shift_reg=0, bit_idx=0, tail_cnt=0, last_q=0.
  - out_bit_valid=0, out_bit=0, out_last=0, out_tail=0.
  - in_ready=0 while rst_n is low.
- Reset mid-byte or mid-tail discards all partial state. The first byte after reset starts at bit 0.
- Handshakes:
  - Input transfer occurs on in_valid&&in_ready at posedge clk.
  - Output transfer occurs on out_bit_valid&&out_bit_ready.
  - Once asserted, out_bit_valid, out_bit, out_last and out_tail stay stable until transfer.
- Registers: out_bit = shift_reg[0]. out_bit_valid = (state!=IDLE). Both are registered state, not combinational from inputs.
- State IDLE:
  - in_ready=1.
  - On input transfer: shift_reg<=in_byte, last_q<=in_last, bit_idx<=0, go to SHIFT.
  - Latency: first bit is visible on out_bit the cycle after acceptance.
- State SHIFT:
  - On output transfer with bit_idx<7: shift_reg>>=1, bit_idx++.
  - On output transfer with bit_idx==7:
    - If last_q && tail enabled: go to TAIL with tail_cnt<=0.
    - Else if in_valid&&in_ready: reload (back-to-back, no bubble).
    - Else: go to IDLE.
  - in_ready = (bit_idx==7) && out_bit_ready && !(last_q && tail enabled). This is a combinational path from out_bit_ready and is accepted.
- out_last:
  - Tail disabled: out_last=1 during bit_idx==7 of a byte with last_q=1.
  - Tail enabled: out_last=1 only on the final tail bit.
- State TAIL:
  - out_bit=0, out_tail=1, in_ready=0.
  - Each output transfer increments tail_cnt.
  - On transfer with tail_cnt==TAIL_BITS-1: out_last was 1; go to IDLE.
- Back-pressure: out_bit_ready=0 holds all state indefinitely. No byte is dropped and no bit is duplicated.
- Simultaneous events: a reload and the final-bit transfer happen in the same cycle. The new byte's bit 0 appears the next cycle.
- Counters: bit_idx is 3 bits and wraps only via reload. tail_cnt is 4 bits.
- Debug: bit_idx is visible hierarchically as dut.bit_idx for the bench.

Optional Feature:
- Macro: BYTE_UNPACKER_TAIL_ZEROS_EN.
- Defined: TAIL state exists; TAIL_BITS zeros are appended after each frame's last byte, and out_tail/out_last behave as above.
- Undefined: no TAIL state or tail_cnt logic. out_tail is tied to 0. out_last marks bit 7 of an in_last byte. in_ready ignores last_q.

Decomposition:
- Shared package viterbi_pkg holds:
  - typedef enum logic [1:0] {UNP_IDLE, UNP_SHIFT, UNP_TAIL} unp_state_t
  - localparam BYTE_W=8
  - localparam default K=7 and TAIL_BITS_DEF=K-1
- Single module, no sub-module. The datapath is one shift register plus two counters.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> out_bit_valid=0, in_ready=0, bit_idx=0; after release in_ready=1.
- Single byte 8'hAD, in_last=1, tail undefined, out_bit_ready=1 -> bits 1,0,1,1,0,1,0,1 on consecutive cycles; out_last only on 8th bit; out_bit_valid=0 the cycle after.
- Burst 8'h12,8'h34,8'h56,8'h78 with in_valid held high -> 32 bits with no idle cycle; repacked bytes match; in_ready pulses only on the bit-7 transfer.
- Random out_bit_ready (~66%) over 125 random bytes -> all 1000 bits match in order; out_bit is stable while stalled; scoreboard count of accepted bytes*8 equals transferred bits plus remaining bits.
- Tail enabled, TAIL_BITS=6, frame 8'hFF,last -> 8 ones then 6 zeros with out_tail=1; out_last only on the 14th bit; in_ready=0 throughout the tail.
- Reset mid-byte after 5 bits of 8'hFF, then send 8'h3C -> bits 0,0,1,1,1,1,0,0 with no residual ones.
